// File: rtl/t_ff_pkg.sv
// Shared constants and next-state source selection for the t_ff toggle bank.
package t_ff_pkg;

    localparam int T_FF_DEF_WIDTH = 1;
    localparam int T_FF_DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        SRC_RESET,
        SRC_LOAD,
        SRC_TOGGLE,
        SRC_HOLD
    } t_ff_src_e;

    // Priority: reset over load over enabled toggle; otherwise hold.
    function automatic t_ff_src_e t_ff_sel_src(input logic reset, input logic load,
                                               input logic ce);
        if (reset)     return SRC_RESET;
        else if (load) return SRC_LOAD;
        else if (ce)   return SRC_TOGGLE;
        else           return SRC_HOLD;
    endfunction

endpackage

// File: rtl/t_ff_bit.sv
// Single toggle cell: synchronous reset to rst_val, parallel load, gated toggle.
module t_ff_bit
    import t_ff_pkg::*;
(
    input  logic CLK,
    input  logic RESET,
    input  logic rst_val,
    input  logic t,
    input  logic ce,
    input  logic load,
    input  logic d,
    output logic q
);

    t_ff_src_e src;

    always_comb src = t_ff_sel_src(RESET, load, ce);

    always_ff @(posedge CLK) begin
        case (src)
            SRC_RESET:  q <= rst_val;
            SRC_LOAD:   q <= d;
            SRC_TOGGLE: q <= q ^ t;
            default:    q <= q;
        endcase
    end

endmodule

// File: rtl/t_ff.sv
// Parameterised bank of T flip-flops with clock enable and parallel load.
// Define T_FF_TOGGLE_CNT_EN to add a saturating count of edges where Q changed.
module t_ff
    import t_ff_pkg::*;
#(
    parameter int               WIDTH       = T_FF_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = T_FF_DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] t,
    input  logic             ce,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN
`ifdef T_FF_TOGGLE_CNT_EN
    ,
    output logic [CNT_W-1:0] toggle_cnt
`endif
);

    if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_bad_param
        $error("t_ff: WIDTH must be 1..64 and CNT_W at least 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_ff_bit u_bit (
            .CLK     (CLK),
            .RESET   (RESET),
            .rst_val (RESET_VALUE[i]),
            .t       (t[i]),
            .ce      (ce),
            .load    (load),
            .d       (d[i]),
            .q       (Q[i])
        );
    end

    assign QN = ~Q;

`ifdef T_FF_TOGGLE_CNT_EN
    // Mirror the cells' next state so only real value changes are counted.
    logic [WIDTH-1:0] q_nxt;
    logic             q_chg;

    always_comb begin
        q_nxt = Q;
        if (load)    q_nxt = d;
        else if (ce) q_nxt = Q ^ t;
    end

    assign q_chg = (q_nxt != Q);

    always_ff @(posedge CLK) begin
        if (RESET)
            toggle_cnt <= '0;
        else if (q_chg && toggle_cnt != {CNT_W{1'b1}})
            toggle_cnt <= toggle_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_t_ff.sv
// Scoreboard bench for t_ff: a 1-bit bank and a 4-bit bank (RESET_VALUE 0101, CNT_W 2).
module tb_t_ff;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       r1 = 1'b0, t1 = 1'b0, ce1 = 1'b0, ld1 = 1'b0, d1 = 1'b0;
    logic       q1, qn1;
    logic       r4 = 1'b0, ce4 = 1'b0, ld4 = 1'b0;
    logic [3:0] t4 = '0, d4 = '0;
    logic [3:0] q4, qn4;
`ifdef T_FF_TOGGLE_CNT_EN
    logic [1:0] cnt4;
`endif

    t_ff #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut1 (
        .CLK(CLK), .RESET(r1), .t(t1), .ce(ce1), .load(ld1), .d(d1), .Q(q1), .QN(qn1)
    );

    t_ff #(.WIDTH(4), .RESET_VALUE(4'b0101), .CNT_W(2)) u_dut4 (
        .CLK(CLK), .RESET(r4), .t(t4), .ce(ce4), .load(ld4), .d(d4), .Q(q4), .QN(qn4)
`ifdef T_FF_TOGGLE_CNT_EN
        , .toggle_cnt(cnt4)
`endif
    );

    typedef struct {
        bit         wide;
        logic [3:0] q;
        logic [1:0] cnt;
        string      name;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [3:0] m_q4;
    logic [1:0] m_cnt = 2'd0;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    // Drive the 1-bit bank for the next edge and queue the expected Q.
    task automatic drv1(input logic r, input logic t, input logic ce, input logic ld,
                        input logic d, input logic eq, input string nm);
        @(negedge CLK);
        r1 = r; t1 = t; ce1 = ce; ld1 = ld; d1 = d;
        sb.push_back('{wide: 1'b0, q: {3'b000, eq}, cnt: 2'd0, name: nm});
    endtask

    // Drive the 4-bit bank; the counter expectation follows the hand-given Q sequence.
    task automatic drv4(input logic r, input logic [3:0] t, input logic ce, input logic ld,
                        input logic [3:0] d, input logic [3:0] eq, input string nm);
        @(negedge CLK);
        r4 = r; t4 = t; ce4 = ce; ld4 = ld; d4 = d;
        if (r)                              m_cnt = 2'd0;
        else if (eq != m_q4 && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
        m_q4 = eq;
        sb.push_back('{wide: 1'b1, q: eq, cnt: m_cnt, name: nm});
    endtask

    // Monitor: one queued expectation per edge, checked just after the edge.
    always begin
        @(posedge CLK);
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            if (!cur.wide) begin
                chk({"q1 ", cur.name}, {3'b000, q1}, cur.q);
                chk({"qn1 ", cur.name}, {3'b000, qn1}, {3'b000, ~cur.q[0]});
            end else begin
                chk({"q4 ", cur.name}, q4, cur.q);
                chk({"qn4 ", cur.name}, qn4, ~cur.q);
`ifdef T_FF_TOGGLE_CNT_EN
                chk({"cnt ", cur.name}, {2'b00, cnt4}, {2'b00, cur.cnt});
`endif
            end
        end
    end

    initial begin
        int k;
        // 1-bit bank: reset dominates toggle, then free toggling and hold
        drv1(1, 1, 1, 0, 0, 0, "rst_a");
        drv1(1, 1, 1, 0, 0, 0, "rst_b");
        drv1(0, 1, 1, 0, 0, 1, "tog_1");
        drv1(0, 1, 1, 0, 0, 0, "tog_2");
        drv1(0, 1, 1, 0, 0, 1, "tog_3");
        drv1(0, 1, 1, 0, 0, 0, "tog_4");
        drv1(0, 0, 1, 0, 0, 0, "hold_a");
        drv1(0, 0, 1, 0, 0, 0, "hold_b");

        // 4-bit bank: enable gating, load priority, reset over load
        drv4(1, 4'b0000, 0, 0, 4'b0000, 4'b0101, "rst4");
        drv4(0, 4'b0000, 0, 1, 4'b0000, 4'b0000, "load0");
        drv4(0, 4'b1010, 0, 0, 4'b0000, 4'b0000, "ce0_a");
        drv4(0, 4'b1010, 0, 0, 4'b0000, 4'b0000, "ce0_b");
        drv4(0, 4'b1010, 1, 0, 4'b0000, 4'b1010, "ce1");
        drv4(0, 4'b1111, 1, 1, 4'b0110, 4'b0110, "load_prio");
        drv4(1, 4'b1111, 1, 1, 4'b1111, 4'b0101, "rst_over_load");

        // mid-sequence reset discards the toggle, toggling resumes next edge
        drv4(0, 4'b1111, 1, 0, 4'b0000, 4'b1010, "seq_a");
        drv4(0, 4'b1111, 1, 0, 4'b0000, 4'b0101, "seq_b");
        drv4(0, 4'b1111, 1, 0, 4'b0000, 4'b1010, "seq_c");
        drv4(1, 4'b1111, 1, 0, 4'b0000, 4'b0101, "mid_rst");
        drv4(0, 4'b1111, 1, 0, 4'b0000, 4'b1010, "resume");

        // counter saturation run (Q checks apply in every build)
        drv4(1, 4'b0001, 1, 0, 4'b0000, 4'b0101, "cnt_rst");
        drv4(0, 4'b0001, 1, 0, 4'b0000, 4'b0100, "cnt_1");
        drv4(0, 4'b0001, 1, 0, 4'b0000, 4'b0101, "cnt_2");
        drv4(0, 4'b0001, 1, 0, 4'b0000, 4'b0100, "cnt_3");
        drv4(0, 4'b0001, 1, 0, 4'b0000, 4'b0101, "cnt_sat_a");
        drv4(0, 4'b0001, 1, 0, 4'b0000, 4'b0100, "cnt_sat_b");
        drv4(1, 4'b0001, 1, 0, 4'b0000, 4'b0101, "cnt_clr");

        k = 0;
        while (sb.size() > 0 && k < 20) begin
            @(posedge CLK);
            k++;
        end
        #2;
        if (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
